// File: rtl/i2c_pkg.sv
// I2C target shared definitions: state encoding,
// R/W and ACK bit values, byte width.
`timescale 1ns/1ps
package i2c_pkg;

  localparam int   I2C_BYTE_W   = 8;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line synchronizer with registered edge detect.
// Optional 3-sample majority filter: I2C_SLAVE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q;
  logic val;
  logic prev_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  // two-flop synchronizer; resets to idle-high bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic h1_q, h2_q;
  logic maj_d, maj_q;

  // majority of the last three synchronized samples
  always_comb begin
    maj_d = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
  end

  // sample history and registered filter output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q  <= 1'b1;
      h2_q  <= 1'b1;
      maj_q <= 1'b1;
    end else begin
      h1_q  <= s2_q;
      h2_q  <= h1_q;
      maj_q <= maj_d;
    end
  end

  assign val = maj_q;
`else
  assign val = s2_q;
`endif

  // edge decode against the previous filtered value
  always_comb begin
    rise_d = val & ~prev_q;
    fall_d = ~val & prev_q;
  end

  // edge register; level is aligned with the edge strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= val;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Single-address I2C target: write bytes out on rx_data,
// read bytes from tx_data. Filter: I2C_SLAVE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_match,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic [I2C_BYTE_W-1:0] shift_d, shift_q;
  logic [I2C_BYTE_W-1:0] rx_data_d, rx_data_q;
  logic phase_d, phase_q;
  logic rw_d, rw_q;
  logic sda_oe_d, sda_oe_q;
  logic rx_valid_d, rx_valid_q;
  logic addr_match_d, addr_match_q;
  logic busy_d, busy_q;

  i2c_line_sync u_scl (
    .clk   (clk),
    .rst   (rst),
    .din   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda (
    .clk   (clk),
    .rst   (rst),
    .din   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // next state: bus conditions first, then bit framing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    rx_valid_d   = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    tx_req       = 1'b0;
    if (stop_det) begin
      state_d      = ST_IDLE;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
    end else if (start_det) begin
      state_d      = ST_ADDR;
      cnt_d        = 4'd7;
      phase_d      = 1'b0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WAIT_STOP: ;
        ST_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_lvl};
          if (cnt_q == 4'd0) begin
            rw_d = sda_lvl;
            // general call (0x00) is never acknowledged
            if (shift_q[6:0] == SLAVE_ADDR && shift_q[6:0] != 7'h00) begin
              state_d = ST_ADDR_ACK;
              phase_d = 1'b0;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
            if (state_q == ST_ADDR_ACK) addr_match_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            cnt_d    = 4'd7;
            if (state_q == ST_WR_ACK || rw_q == I2C_RW_WRITE) begin
              state_d = ST_WR_DATA;
            end else begin
              tx_req   = 1'b1;
              shift_d  = {tx_data[6:0], 1'b0};
              sda_oe_d = ~tx_data[7];
              state_d  = ST_RD_DATA;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_lvl};
          if (cnt_q == 4'd0) begin
            rx_data_d  = {shift_q[6:0], sda_lvl};
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = ST_WR_ACK;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RD_DATA: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            cnt_d    = cnt_q - 4'd1;
          end
        end
        // on ACK the next byte starts at the following fall (count 8)
        ST_RD_ACK: if (scl_rise) begin
          if (sda_lvl == I2C_ACK) begin
            tx_req  = 1'b1;
            shift_d = tx_data;
            cnt_d   = 4'd8;
            state_d = ST_RD_DATA;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged master on a pulled-up
// SDA line, scoreboard queues for write and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int Q = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_match;
  logic       busy;
  wire        sda_bus;

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int txr_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];
  bit slv_drove = 0;
  bit watch_busy = 0;
  bit busy_drop = 0;

  i2c_slave_rx #(.SLAVE_ADDR(7'h42)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda_bus),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .addr_match (addr_match),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // output monitor: scoreboard pops, pulse counts, bus watchers
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check("rx_sb_nonempty", 32'(rx_q.size() > 0), 32'd1);
      if (rx_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
    end
    if (tx_req) txr_cnt++;
    if (!m_oe && sda_bus === 1'b0) slv_drove = 1;
    if (watch_busy && !busy) busy_drop = 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic bit_x(input logic b, output logic r);
    m_oe = ~b;
    #Q scl = 1'b1;
    #Q r = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q m_oe = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1;
    #Q scl = 1'b1;
    #Q m_oe = 1'b0;
    #(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, input logic [7:0] nxt,
                         output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
    if (!mack) begin
      tx_data = nxt;
      rd_q.push_back(nxt);
    end
    bit_x(mack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    logic [7:0] gexp;
    int         n0;
    int         t0;

    #107;
    check("reset_outs", 32'({rx_data, rx_valid, tx_req, addr_match, busy}), 32'd0);
    check("reset_sda", 32'(sda_bus), 32'd1);
    rst = 1'b0;
    #200;

    // write 0x42 <- 0xA5
    n0 = rx_cnt;
    i2c_start();
    check("wr_busy", 32'(busy), 32'd1);
    wr_byte(8'h84, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    check("wr_addr_match", 32'(addr_match), 32'd1);
    rx_q.push_back(8'hA5);
    wr_byte(8'hA5, ack);
    check("wr_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("wr_busy_off", 32'(busy), 32'd0);
    check("wr_am_off", 32'(addr_match), 32'd0);
    check("wr_rx_cnt", 32'(rx_cnt - n0), 32'd1);
    check("wr_rx_hold", 32'(rx_data), 32'hA5);

    // address mismatch
    n0 = rx_cnt;
    slv_drove = 0;
    i2c_start();
    wr_byte(8'hA0, ack);
    check("mm_addr_nack", 32'(ack), 32'd1);
    wr_byte(8'h11, ack);
    check("mm_data_nack", 32'(ack), 32'd1);
    check("mm_am", 32'(addr_match), 32'd0);
    check("mm_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("mm_no_drive", 32'(slv_drove), 32'd0);
    check("mm_rx_cnt", 32'(rx_cnt - n0), 32'd0);

    // read 0x3C (ACK) then 0xF0 (NACK)
    t0 = txr_cnt;
    tx_data = 8'h3C;
    rd_q.push_back(8'h3C);
    i2c_start();
    wr_byte(8'h85, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    rd_byte(1'b0, 8'hF0, d);
    check("rd_byte0", 32'(d), 32'(rd_q.pop_front()));
    rd_byte(1'b1, 8'h00, d);
    check("rd_byte1", 32'(d), 32'(rd_q.pop_front()));
    check("rd_release", 32'(sda_bus), 32'd1);
    check("rd_txreq_cnt", 32'(txr_cnt - t0), 32'd2);
    i2c_stop();

    // repeated START: write 0x12 then read without STOP
    i2c_start();
    busy_drop = 0;
    watch_busy = 1;
    wr_byte(8'h84, ack);
    rx_q.push_back(8'h12);
    wr_byte(8'h12, ack);
    check("rs_wr_ack", 32'(ack), 32'd0);
    i2c_start();
    check("rs_am_clr", 32'(addr_match), 32'd0);
    tx_data = 8'h5A;
    rd_q.push_back(8'h5A);
    wr_byte(8'h85, ack);
    check("rs_rd_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, 8'h00, d);
    check("rs_rd_byte", 32'(d), 32'(rd_q.pop_front()));
    check("rs_rx_data", 32'(rx_data), 32'h12);
    watch_busy = 0;
    check("rs_busy_held", 32'(busy_drop), 32'd0);
    i2c_stop();

    // reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      gexp = 8'h84;
      bit_x(gexp[i], r);
    end
    m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q;
    check("rst_pre_ack", 32'(sda_bus), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_sda_rel", 32'(sda_bus), 32'd1);
    check("rst_outs", 32'({rx_data, rx_valid, tx_req, addr_match, busy}), 32'd0);
    #18;
    #Q scl = 1'b0;
    #Q rst = 1'b0;
    #Q;
    i2c_stop();
    n0 = rx_cnt;
    i2c_start();
    wr_byte(8'h84, ack);
    check("rst_next_ack", 32'(ack), 32'd0);
    rx_q.push_back(8'h77);
    wr_byte(8'h77, ack);
    i2c_stop();
    check("rst_next_rx", 32'(rx_cnt - n0), 32'd1);
    check("rst_next_data", 32'(rx_data), 32'h77);

    // 1-clk low glitch on SCL during the first data bit of 0xA5
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    gexp = 8'hA5;
`else
    gexp = 8'hD2;
`endif
    n0 = rx_cnt;
    i2c_start();
    wr_byte(8'h84, ack);
    rx_q.push_back(gexp);
    m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q;
    #20 scl = 1'b0;
    #20 scl = 1'b1;
    #(Q-40) scl = 1'b0;
    #Q;
    for (int i = 6; i >= 0; i--) begin
      d = 8'hA5;
      bit_x(d[i], r);
    end
    bit_x(1'b1, ack);
    i2c_stop();
    check("gl_rx_cnt", 32'(rx_cnt - n0), 32'd1);
    check("gl_rx_data", 32'(rx_data), 32'(gexp));

    check("sb_rx_left", 32'(rx_q.size()), 32'd0);
    check("sb_rd_left", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Single-address I2C target that sits on the same SDA/SCL bus as the team's `i2c_master` and consumes the transactions the master produces. It runs entirely in the system clock domain. SCL and SDA are oversampled through synchronizers, and START, STOP, bit and ACK framing are decoded by a state machine. Write bytes are delivered to local logic as `rx_data`/`rx_valid`; read bytes are taken from `tx_data` and shifted out on SDA.

## Interface
- `SLAVE_ADDR`, default 7'h42: 7-bit bus address this target answers.
- `clk` input 1: system clock (50 MHz nominal, ≥ 20× SCL).
- `rst` input 1: reset; asynchronous, active-high.
- `scl` input 1: bus clock, sampled only; never driven.
- `sda` inout 1: open-drain data; driven `1'b0` or `1'bz` only, never `1'b1`.
- `tx_data` input 8: byte returned on a read; sampled on a `tx_req` cycle.
- `rx_data` output 8: last received write byte; holds value until the next byte.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated.
- `tx_req` output 1: one-cycle pulse; `tx_data` captured this cycle.
- `addr_match` output 1: high from own-address ACK until STOP or repeated START.
- `busy` output 1: high from START until STOP.

## Operation
- Sync: `scl`/`sda` each pass a 2-flop synchronizer. Edges are taken from the synchronized value and its 1-cycle-delayed copy.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Both are recognized in any state, and STOP/START are evaluated before bit sampling in the same cycle.
- START → ADDR. Bit counter is set to 7; `busy` goes to 1 and `addr_match` to 0. This also covers repeated START.
- STOP → IDLE. SDA is released immediately; `busy` and `addr_match` go to 0.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first on SCL rising edges. After bit 0, if `[7:1]==SLAVE_ADDR`, go to ADDR_ACK; otherwise go to WAIT_STOP.
  - ADDR_ACK: on the next SCL falling edge drive SDA low and set `addr_match`=1. On the following SCL falling edge release SDA. If R/W=0, go to WR_DATA; if R/W=1, pulse `tx_req`, load the shifter with `tx_data`, drive bit 7, and go to RD_DATA.
  - WR_DATA: shifts 8 bits. After bit 0, `rx_data` ← shifter, pulse `rx_valid`, go to WR_ACK.
  - WR_ACK: drives ACK low for one SCL period, same edges as ADDR_ACK, then returns to WR_DATA. Multi-byte writes are unlimited.
  - RD_DATA: changes SDA on each SCL falling edge. A 1 bit is output as `z`, a 0 bit as `0`. After the falling edge that follows bit 0, release SDA and go to RD_ACK.
  - RD_ACK: samples SDA on the SCL rising edge. ACK (0) → pulse `tx_req`, reload, go to RD_DATA. NACK (1) → go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignores all traffic until STOP or START.
- General-call address (0x00) is not acknowledged.
- Reset: state IDLE, SDA released, shifter and counter cleared. All outputs 0: `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `addr_match`=0, `busy`=0. Reset mid-transfer behaves the same; the bus is released within the reset assertion, with no clock needed.

## Timing
- Bus-to-detect latency: 3 clk cycles (2 sync + 1 edge register) without the filter, 5 with it.
- `rx_valid` is asserted in the clk cycle after detection of the SCL rising edge that samples data bit 0.
- `tx_req` is asserted in the same cycle that the shifter loads.
- SDA drive changes one clk after the detected SCL falling edge. Data setup on the bus therefore equals SCL low time minus 4–6 clk.
- No clock stretching; SCL is never held.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: a 3-sample majority filter is added after each synchronizer. Pulses of 1 clk on SCL or SDA are suppressed, and latency grows by 2 cycles.
- Undefined: no filter; every synchronized transition is treated as an edge.

## Structure
- Package `i2c_pkg`:
  - state encoding constants;
  - `I2C_RW_READ`=1 / `I2C_RW_WRITE`=0;
  - `I2C_ACK`=0 / `I2C_NACK`=1;
  - byte width 8.
- Sub-module `i2c_line_sync`, instantiated twice (SCL, SDA). It contains the synchronizer, the optional filter, and produces outputs `level`, `rise` and `fall`.

## Test plan
- Write: START, 0x84, 0xA5, STOP → ACK low on both 9th clocks, `rx_data`=0xA5, one `rx_valid` pulse, `busy` returns 0 after STOP.
- Address mismatch: START, 0xA0, 0x11 → SDA never driven, no `rx_valid`, `addr_match`=0, state WAIT_STOP until STOP.
- Read: START, 0x85, `tx_data`=0x3C, master ACK, then `tx_data`=0xF0, master NACK, STOP → bus carries 0x3C then 0xF0, two `tx_req` pulses, SDA released after NACK.
- Repeated START: write 0x84, 0x12, then START, 0x85 with no STOP → `rx_data`=0x12, then the read proceeds, `busy` stays 1 throughout.
- Reset mid-byte: assert `rst` while driving an ACK → SDA goes `z` during reset, all outputs 0, next START is decoded normally.
- Glitch: 1-clk low pulse on SCL during a data bit → with `I2C_SLAVE_GLITCH_FILTER_EN` the bit count is unchanged; without it an extra bit is counted.
